// File: rtl/rom_reader_if.sv
// rom_reader_if: command, ROM and downstream handshake signals of the ROM reader
interface rom_reader_if #(
  parameter int ADR_W  = 3,
  parameter int DATA_W = 4
);
  logic              start;
  logic              dir;
  logic              loop;
  logic              stop;
  logic [ADR_W-1:0]  ROM_adr;
  logic [DATA_W-1:0] ROM_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  modport master (
    input  start, dir, loop, stop, ROM_data, out_ready,
    output ROM_adr, out_data, out_valid, busy, done
  );
  modport slave (
    output start, dir, loop, stop, ROM_data, out_ready,
    input  ROM_adr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/rom_reader.sv
// rom_reader: steps a combinational ROM address and presents each word over valid/ready
module rom_reader #(
  parameter int ADR_W  = 3,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input logic         clk,
  input logic         rst_n,
  rom_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;
  localparam logic [ADR_W-1:0] LAST = ADR_W'(DEPTH - 1);
  state_t            state;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] data;
  logic              valid, done, dir_q, loop_q, stop_q;
  logic              at_end;
  assign at_end = dir_q ? (adr == '0) : (adr == LAST);
  // pass sequencing: latch the command, fetch a word, hold it until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      adr    <= '0;
      data   <= '0;
      valid  <= 1'b0;
      done   <= 1'b0;
      dir_q  <= 1'b0;
      loop_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && bus.stop) stop_q <= 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          dir_q  <= bus.dir;
          loop_q <= bus.loop;
          stop_q <= 1'b0;
          adr    <= bus.dir ? LAST : '0;
          state  <= FETCH;
        end
        FETCH: begin
          data  <= bus.ROM_data;
          valid <= 1'b1;
          state <= PRESENT;
        end
        PRESENT: if (valid && bus.out_ready) begin
          valid <= 1'b0;
          if ((at_end && !loop_q) || stop_q || bus.stop) begin
            done   <= 1'b1;
            stop_q <= 1'b0;
            state  <= IDLE;
          end else begin
            adr   <= dir_q ? (adr == '0 ? LAST : adr - ADR_W'(1))
                           : (adr == LAST ? '0 : adr + ADR_W'(1));
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.ROM_adr   = adr;
  assign bus.out_data  = data;
  assign bus.out_valid = valid;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
endmodule

// File: doc/rom_reader.md
# rom_reader

Sequential read initiator for the 8-entry × 4-bit combinational ROM. On a start command it drives the ROM address in ascending or descending order and registers each returned word. It presents every word to a downstream consumer over a valid/ready handshake. It sits between the ROM and any block that consumes a ROM sequence, such as a display driver or a pattern generator, and replaces the hand-driven address stepping used in simulation.

## Interface
Parameters:
- ADR_W, 3, ROM address width
- DATA_W, 4, ROM data width
- DEPTH, 8, number of ROM words; the last address is DEPTH-1

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  begin a read pass; sampled only in IDLE
- dir  input  1  0 = ascending (0 → DEPTH-1), 1 = descending (DEPTH-1 → 0); latched at start
- loop  input  1  1 = wrap around and repeat indefinitely; latched at start
- stop  input  1  ends a pass after the word currently being presented; sticky until the pass ends
- ROM_adr  output  ADR_W  address to the ROM
- ROM_data  input  DATA_W  combinational ROM output for ROM_adr
- out_data  output  DATA_W  registered ROM word
- out_valid  output  1  out_data holds a word that has not yet been transferred
- out_ready  input  1  consumer accepts the word
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a pass ends

## Operation
- Reset (rst_n low at a clock edge): state = IDLE, ROM_adr = 0, out_data = 0, out_valid = 0, busy = 0, done = 0, stop request cleared. This applies in any state; a pass in progress is aborted with no done pulse.
- Three-state FSM:
  - **IDLE**: done returns to 0 here.
    - If start = 1: latch dir and loop, clear the stop request, set ROM_adr = dir ? DEPTH-1 : 0, and go to FETCH.
  - **FETCH**, one cycle:
    - out_data ← ROM_data.
    - out_valid ← 1.
    - Go to PRESENT.
  - **PRESENT**: hold out_data and out_valid until the handshake (out_valid & out_ready at a clock edge). At the handshake, out_valid ← 0, then one of the following:
    - **End of pass**: (the end address is reached and loop = 0) or the stop request is set. Go to IDLE with done ← 1.
    - **Otherwise**: step ROM_adr (+1 ascending, −1 descending, modulo DEPTH, so 7→0 and 0→7) and go to FETCH.
- End address: DEPTH-1 when ascending, 0 when descending.
- Stop request: set by stop = 1 in any state other than IDLE. A stop sampled on the same edge as a handshake ends the pass at that handshake.
- start is ignored while busy = 1.
- ROM_adr holds its value in IDLE after a pass, and only changes on start or at a handshake.
- out_data is stable for as long as out_valid = 1. It is never overwritten by an untransferred word.

## Timing
- start sampled at edge k: ROM_adr is valid after edge k, and busy = 1 after edge k.
- Edge k+1: out_data and out_valid = 1 become valid.
- Handshake at edge m:
  - If the pass continues: the next address is driven after edge m, and the next word is valid after edge m+1.
  - If the pass ends: busy = 0 and done = 1 after edge m, and done = 0 after edge m+1.
- Throughput with out_ready held at 1: one word every 2 cycles. A full non-looping pass occupies 2·DEPTH cycles.
- No combinational path from out_ready or ROM_data to any output. ROM_adr is registered.

## Test plan
The bench ROM model returns data = 8 + adr (adr 0 → 0x8, adr 7 → 0xF).

- **Ascending pass**: reset, then start = 1 with dir = 0, loop = 0, out_ready = 1 tied high. Required: out_data sequence 0x8, 0x9, …, 0xF, 8 handshakes at edges 2, 4, …, 16 after the start edge, done pulse for one cycle after edge 16, busy low after edge 16.
- **Descending pass**: dir = 1, otherwise as above. Required: out_data 0xF down to 0x8, ROM_adr 7 → 0, done after the 8th handshake.
- **Backpressure**: ascending, out_ready low for 5 cycles while the word for adr 3 (0xB) is presented. Required: out_valid stays 1, out_data = 0xB and ROM_adr = 3 are stable throughout, exactly one transfer occurs when out_ready rises, and the sequence continues with 0xC.
- **Loop wrap and stop**: ascending with loop = 1. Required: 0xF is followed by 0x8 (ROM_adr 7 → 0) with no done pulse. Pulse stop while 0x9 is presented; required: the pass ends at the 0x9 handshake with one done pulse, and busy falls to 0.
- **Start while busy, and reset mid-pass**:
  - Assert start during a pass. Required: no restart, and dir/loop are unchanged.
  - Drive rst_n = 0 for one edge while out_valid = 1. Required: all outputs at reset values after that edge, no done pulse, and a new start then behaves as in the ascending pass.
